// File: rtl/writeback_stage_if.sv
// Commit-trace handshake between writeback_stage (master) and a trace monitor (slave).
// Widths default to 32 bits unless XLEN / PC_WIDTH / INSTR_WIDTH are predefined.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface writeback_stage_if;
  logic                    trace_valid;
  logic                    trace_ready;
  logic [`PC_WIDTH-1:0]    trace_pc;
  logic [`PC_WIDTH-1:0]    trace_npc;
  logic [`INSTR_WIDTH-1:0] trace_instr;
  logic                    trace_wen;
  logic [4:0]              trace_wdst;
  logic [`XLEN-1:0]        trace_wdata;

  modport master (
    output trace_valid, trace_pc, trace_npc, trace_instr, trace_wen, trace_wdst, trace_wdata,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_npc, trace_instr, trace_wen, trace_wdst, trace_wdata,
    output trace_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: result select, 32x XLEN regfile with write-through bypass, retire counter,
// and an optional commit-trace FIFO built only when WB_COMMIT_TRACE_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module writeback_stage #(
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [`INSTR_WIDTH-1:0] MD_instr_i,
  input  logic                    MD_sel_reg_i,
  input  logic [`XLEN-1:0]        MD_valM_i,
  input  logic [`XLEN-1:0]        MD_valE_i,
  input  logic                    MD_need_dstE_i,
  input  logic [4:0]              MD_dstE_i,
  input  logic [`PC_WIDTH-1:0]    MD_PC_i,
  input  logic [`PC_WIDTH-1:0]    MD_nPC_i,
  input  logic                    MD_commit_i,
  input  logic [4:0]              rs1_addr_i,
  input  logic [4:0]              rs2_addr_i,
  output logic [`XLEN-1:0]        rs1_data_o,
  output logic [`XLEN-1:0]        rs2_data_o,
  output logic                    W_we_o,
  output logic [4:0]              W_dstE_o,
  output logic [`XLEN-1:0]        W_valW_o,
  output logic                    W_stall_o,
  output logic [63:0]             instret_o,
  writeback_stage_if.master       trace
);

  logic [`XLEN-1:0] val_w;
  logic             accept;
  logic [`XLEN-1:0] regs_q [32];
  logic [63:0]      instret_q;

  assign val_w    = MD_sel_reg_i ? MD_valM_i : MD_valE_i;
  assign W_valW_o = val_w;
  assign W_dstE_o = MD_dstE_i;
  assign accept   = MD_commit_i & ~W_stall_o;
  assign W_we_o   = accept & MD_need_dstE_i & (MD_dstE_i != 5'd0);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (W_we_o) begin
      regs_q[MD_dstE_i] <= val_w;
    end
  end

  // Bypass lets decode see this cycle's write before it lands in the array.
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (rs1_addr_i == 5'd0) begin
      rs1_data_o = '0;
    end else if (W_we_o && (rs1_addr_i == MD_dstE_i)) begin
      rs1_data_o = val_w;
    end
  end

  always_comb begin
    rs2_data_o = regs_q[rs2_addr_i];
    if (rs2_addr_i == 5'd0) begin
      rs2_data_o = '0;
    end else if (W_we_o && (rs2_addr_i == MD_dstE_i)) begin
      rs2_data_o = val_w;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (accept) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;

`ifdef WB_COMMIT_TRACE_EN
  localparam int unsigned PtrW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(TRACE_DEPTH);

  typedef struct packed {
    logic [`PC_WIDTH-1:0]    pc;
    logic [`PC_WIDTH-1:0]    npc;
    logic [`INSTR_WIDTH-1:0] instr;
    logic                    wen;
    logic [4:0]              wdst;
    logic [`XLEN-1:0]        wdata;
  } trace_t;

  trace_t          mem_q [TRACE_DEPTH];
  trace_t          head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_full, push, pop;

  assign fifo_full = (count_q == DepthCnt);
  assign W_stall_o = MD_commit_i & fifo_full;
  assign push      = accept;
  assign pop       = trace.trace_valid & trace.trace_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: MD_PC_i, npc: MD_nPC_i, instr: MD_instr_i, wen: W_we_o,
                           wdst: MD_dstE_i, wdata: val_w};
    end
  end

  assign trace.trace_valid = (count_q != '0);
  assign head              = trace.trace_valid ? mem_q[rd_ptr_q] : '0;
  assign trace.trace_pc    = head.pc;
  assign trace.trace_npc   = head.npc;
  assign trace.trace_instr = head.instr;
  assign trace.trace_wen   = head.wen;
  assign trace.trace_wdst  = head.wdst;
  assign trace.trace_wdata = head.wdata;
`else
  logic unused_trace;

  assign unused_trace      = ^{trace.trace_ready, MD_PC_i, MD_nPC_i, MD_instr_i};
  assign W_stall_o         = 1'b0;
  assign trace.trace_valid = 1'b0;
  assign trace.trace_pc    = '0;
  assign trace.trace_npc   = '0;
  assign trace.trace_instr = '0;
  assign trace.trace_wen   = 1'b0;
  assign trace.trace_wdst  = '0;
  assign trace.trace_wdata = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a driver predicts each cycle's outputs and each trace
// record from an architectural model; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_writeback_stage;
  localparam int TraceDepth = 4;
`ifdef WB_COMMIT_TRACE_EN
  localparam bit TraceEn = 1'b1;
`else
  localparam bit TraceEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] md_instr = '0, md_valm = '0, md_vale = '0, md_pc = '0, md_npc = '0;
  logic        md_sel_reg = 1'b0, md_need_dste = 1'b0, md_commit = 1'b0;
  logic [4:0]  md_dste = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data, w_valw;
  logic        w_we, w_stall;
  logic [4:0]  w_dste;
  logic [63:0] instret;

  writeback_stage_if trace_bus ();

  writeback_stage #(.TRACE_DEPTH(TraceDepth)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .MD_instr_i     (md_instr),
    .MD_sel_reg_i   (md_sel_reg),
    .MD_valM_i      (md_valm),
    .MD_valE_i      (md_vale),
    .MD_need_dstE_i (md_need_dste),
    .MD_dstE_i      (md_dste),
    .MD_PC_i        (md_pc),
    .MD_nPC_i       (md_npc),
    .MD_commit_i    (md_commit),
    .rs1_addr_i     (rs1_addr),
    .rs2_addr_i     (rs2_addr),
    .rs1_data_o     (rs1_data),
    .rs2_data_o     (rs2_data),
    .W_we_o         (w_we),
    .W_dstE_o       (w_dste),
    .W_valW_o       (w_valw),
    .W_stall_o      (w_stall),
    .instret_o      (instret),
    .trace          (trace_bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] valw;
    logic        stall;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [63:0] instret;
    logic        tvalid;
  } cyc_t;

  typedef struct {
    logic [31:0] pc, npc, instr;
    logic        wen;
    logic [4:0]  wdst;
    logic [31:0] wdata;
  } tr_t;

  cyc_t cyc_q [$];
  tr_t  exp_trace [$];

  // Architectural model: register array, retire count, trace occupancy.
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  int          m_count;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instret = '0;
    m_count   = 0;
    exp_trace.delete();
  endtask

  task automatic drive(input bit commit, input bit need, input logic [4:0] dst, input bit sel,
                       input logic [31:0] valm, input logic [31:0] vale, input logic [31:0] pc,
                       input logic [31:0] instr, input bit ready, input logic [4:0] r1,
                       input logic [4:0] r2, output bit stalled);
    cyc_t        e;
    bit          accept, pop;
    logic [31:0] valw;
    @(posedge clk_i);
    #1;
    md_commit = commit; md_need_dste = need; md_dste = dst; md_sel_reg = sel;
    md_valm = valm; md_vale = vale; md_pc = pc; md_npc = pc + 32'd4; md_instr = instr;
    trace_bus.trace_ready = ready; rs1_addr = r1; rs2_addr = r2;

    stalled = TraceEn && commit && (m_count == TraceDepth);
    accept  = commit && !stalled;
    valw    = sel ? valm : vale;
    e.we      = accept && need && (dst != 0);
    e.dst     = dst;
    e.valw    = valw;
    e.stall   = stalled;
    e.rs1d    = (r1 == 0) ? 32'd0 : ((e.we && r1 == dst) ? valw : m_regs[r1]);
    e.rs2d    = (r2 == 0) ? 32'd0 : ((e.we && r2 == dst) ? valw : m_regs[r2]);
    e.instret = m_instret;
    e.tvalid  = TraceEn && (m_count != 0);
    cyc_q.push_back(e);

    pop = TraceEn && (m_count != 0) && ready;
    if (accept) begin
      m_instret = m_instret + 64'd1;
      if (e.we) m_regs[dst] = valw;
      if (TraceEn) begin
        exp_trace.push_back('{pc: pc, npc: pc + 32'd4, instr: instr, wen: e.we, wdst: dst,
                              wdata: valw});
        m_count++;
      end
    end
    if (pop) m_count--;
  endtask

  task automatic bubble(input bit ready, input logic [4:0] r1);
    bit s;
    drive(1'b0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h77, 32'h0, 32'h0, ready, r1, 5'd0, s);
  endtask

  always @(negedge clk_i) begin
    if (rst_n) begin
      if (cyc_q.size() > 0) begin
        cyc_t e;
        e = cyc_q.pop_front();
        chk("W_we", {63'd0, w_we}, {63'd0, e.we});
        chk("W_dstE", {59'd0, w_dste}, {59'd0, e.dst});
        chk("W_valW", {32'd0, w_valw}, {32'd0, e.valw});
        chk("W_stall", {63'd0, w_stall}, {63'd0, e.stall});
        chk("rs1_data", {32'd0, rs1_data}, {32'd0, e.rs1d});
        chk("rs2_data", {32'd0, rs2_data}, {32'd0, e.rs2d});
        chk("instret", instret, e.instret);
        chk("trace_valid", {63'd0, trace_bus.trace_valid}, {63'd0, e.tvalid});
      end
      if (trace_bus.trace_valid && trace_bus.trace_ready) begin
        if (exp_trace.size() == 0) begin
          chk("trace_unexpected_pop", 64'd1, 64'd0);
        end else begin
          tr_t t;
          t = exp_trace.pop_front();
          chk("trace_pc", {32'd0, trace_bus.trace_pc}, {32'd0, t.pc});
          chk("trace_npc", {32'd0, trace_bus.trace_npc}, {32'd0, t.npc});
          chk("trace_instr", {32'd0, trace_bus.trace_instr}, {32'd0, t.instr});
          chk("trace_wen_wdst", {58'd0, trace_bus.trace_wen, trace_bus.trace_wdst},
              {58'd0, t.wen, t.wdst});
          chk("trace_wdata", {32'd0, trace_bus.trace_wdata}, {32'd0, t.wdata});
        end
      end else if (!trace_bus.trace_valid) begin
        chk("trace_head_zero", {26'd0, trace_bus.trace_wen, trace_bus.trace_wdst,
            trace_bus.trace_wdata} | {32'd0, trace_bus.trace_pc ^ trace_bus.trace_instr},
            64'd0);
      end
    end
  end

  initial begin
    bit          s;
    bit          hold;
    bit          c, nd, sl, rdy;
    logic [4:0]  d, a1, a2;
    logic [31:0] vm, ve, pc, ins;

    trace_bus.trace_ready = 1'b0;
    model_reset();
    #12;
    chk("reset_instret", instret, 64'd0);
    chk("reset_trace_valid", {63'd0, trace_bus.trace_valid}, 64'd0);
    rs1_addr = 5'd7;
    #1;
    chk("reset_rs1", {32'd0, rs1_data}, 64'd0);
    rst_n = 1'b1;

    // addi x5; dst x0; load x3; bubble aimed at x3
    drive(1, 1, 5'd5, 0, 32'h0, 32'h1234, 32'h100, 32'h00500293, 0, 5'd5, 5'd0, s);
    drive(1, 1, 5'd0, 0, 32'h0, 32'hFFFF, 32'h104, 32'h00000013, 0, 5'd5, 5'd0, s);
    drive(1, 1, 5'd3, 1, 32'hAA, 32'h55, 32'h108, 32'h0000a183, 0, 5'd0, 5'd5, s);
    bubble(1'b0, 5'd3);
    bubble(1'b0, 5'd3);
    for (int i = 0; i < 4; i++) bubble(1'b1, 5'd3);

    // Five back-to-back commits into a stalled trace port
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'(8 + i), 0, 32'h0, 32'(32'h1000 + i), 32'(32'h200 + 4 * i),
            32'(32'hABC0 + i), 0, 5'(8 + i), 5'd5, s);
    end
    drive(1, 1, 5'd12, 0, 32'h0, 32'h1004, 32'h210, 32'hABC4, 1, 5'd12, 5'd8, s);
    drive(1, 1, 5'd12, 0, 32'h0, 32'h1004, 32'h210, 32'hABC4, 0, 5'd12, 5'd8, s);
    for (int i = 0; i < 6; i++) bubble(1'b1, 5'd12);

    // Two entries in flight, then an asynchronous reset pulse mid-cycle
    drive(1, 1, 5'd6, 0, 32'h0, 32'h66, 32'h300, 32'h1, 0, 5'd6, 5'd0, s);
    drive(1, 1, 5'd7, 0, 32'h0, 32'h67, 32'h304, 32'h2, 0, 5'd7, 5'd0, s);
    bubble(1'b0, 5'd6);
    @(negedge clk_i);
    #2;
    rst_n = 1'b0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd7;
    #1;
    chk("midreset_trace_valid", {63'd0, trace_bus.trace_valid}, 64'd0);
    chk("midreset_instret", instret, 64'd0);
    chk("midreset_rs1", {32'd0, rs1_data}, 64'd0);
    chk("midreset_rs2", {32'd0, rs2_data}, 64'd0);
    model_reset();
    @(posedge clk_i);
    #3;
    rst_n = 1'b1;

    // Randomized traffic; a stalled instruction is held until accepted
    hold = 1'b0;
    {c, nd, sl, d, vm, ve, pc, ins} = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        c   = ($urandom_range(0, 9) < 8);
        nd  = ($urandom_range(0, 3) != 0);
        sl  = $urandom_range(0, 1) == 1;
        d   = 5'($urandom_range(0, 7));
        vm  = $urandom;
        ve  = $urandom;
        pc  = $urandom & 32'hFFFF_FFFC;
        ins = $urandom;
      end
      rdy = ($urandom_range(0, 2) == 0);
      a1  = ($urandom_range(0, 1) == 1) ? d : 5'($urandom_range(0, 7));
      a2  = 5'($urandom_range(0, 31));
      drive(c, nd, d, sl, vm, ve, pc, ins, rdy, a1, a2, s);
      hold = s;
    end

    for (int i = 0; i < 3 * TraceDepth && m_count != 0; i++) bubble(1'b1, 5'd0);
    bubble(1'b0, 5'd0);
    @(negedge clk_i);
    #1;
    chk("trace_drained", 64'(exp_trace.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
